// File: rtl/hwpe_ctrl_package.sv
// Shared uloop interface types and the issuer state encoding for the HWPE controller.
`default_nettype none

package hwpe_ctrl_package;

    localparam int unsigned ULOOP_NB_REG    = 4;
    localparam int unsigned ULOOP_REG_WIDTH = 32;
    localparam int unsigned ULOOP_NB_LOOPS  = 6;
    localparam int unsigned ULOOP_CNT_WIDTH = 16;

    typedef struct packed {
        logic enable;
        logic clear;
    } ctrl_uloop_t;

    typedef struct packed {
        logic                                             done;
        logic                                             valid;
        logic [ULOOP_NB_REG-1:0][ULOOP_REG_WIDTH-1:0]     offs;
        logic [ULOOP_NB_LOOPS-1:0][ULOOP_CNT_WIDTH-1:0]   idx;
    } flags_uloop_t;

    // One buffered uloop step as stored in the issuer FIFO.
    typedef struct packed {
        logic [ULOOP_NB_REG-1:0][ULOOP_REG_WIDTH-1:0]     offs;
        logic [ULOOP_NB_LOOPS-1:0][ULOOP_CNT_WIDTH-1:0]   idx;
        logic                                             done;
    } uloop_issuer_entry_t;

    typedef enum logic [2:0] {
        ISS_IDLE  = 3'd0,
        ISS_CLEAR = 3'd1,
        ISS_REQ   = 3'd2,
        ISS_WAIT  = 3'd3,
        ISS_DRAIN = 3'd4,
        ISS_DONE  = 3'd5
    } uloop_issuer_state_t;

endpackage

`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_issuer_fifo.sv
// First-word fall-through FIFO with occupancy; push and pop are both honoured when full.
`default_nettype none

module hwpe_ctrl_uloop_issuer_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    pop_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  occupancy_o
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam int unsigned OCC_WIDTH = PTR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;
    logic                  do_push, do_pop;

    assign empty_o     = (occ_q == '0);
    assign full_o      = (occ_q == OCC_WIDTH'(DEPTH));
    assign occupancy_o = occ_q;
    assign data_o      = mem_q[rd_ptr_q];

    // A pop frees the slot the simultaneous push lands in when full.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
            end
            occ_d = occ_q + OCC_WIDTH'(do_push) - OCC_WIDTH'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hwpe_ctrl_uloop_issuer.sv
// Uloop initiator: issues enable/clear to the uloop engine and streams returned offsets/indices.
// Define HWPE_CTRL_ULOOP_ISSUER_PREFETCH_EN to let the engine run ahead up to FIFO_DEPTH steps.
`default_nettype none

module hwpe_ctrl_uloop_issuer
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned NB_REG     = ULOOP_NB_REG,
    parameter int unsigned REG_WIDTH  = ULOOP_REG_WIDTH,
    parameter int unsigned NB_LOOPS   = ULOOP_NB_LOOPS,
    parameter int unsigned CNT_WIDTH  = ULOOP_CNT_WIDTH,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output ctrl_uloop_t                   ctrl_o,
    input  flags_uloop_t                  flags_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [NB_REG*REG_WIDTH-1:0]   offs_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0] idx_o,
    output logic                          last_o,
    output logic [CNT_WIDTH-1:0]          iter_cnt_o
);

    localparam int unsigned OCC_WIDTH = $clog2(FIFO_DEPTH) + 1;

    uloop_issuer_state_t   state_q, state_d;
    logic [CNT_WIDTH-1:0]  iter_cnt_q, iter_cnt_d;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, issue_ok;
    logic [OCC_WIDTH-1:0]  fifo_occ;
    uloop_issuer_entry_t   fifo_wdata, head;

    assign fifo_wdata = '{offs: flags_i.offs, idx: flags_i.idx, done: flags_i.done};

    hwpe_ctrl_uloop_issuer_fifo #(
        .DATA_WIDTH ($bits(uloop_issuer_entry_t)),
        .DEPTH      (FIFO_DEPTH)
    ) i_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (fifo_push),
        .data_i      (fifo_wdata),
        .pop_i       (fifo_pop),
        .data_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .occupancy_o (fifo_occ)
    );

    assign valid_o    = ~fifo_empty;
    assign fifo_pop   = valid_o & ready_i;
    assign last_o     = valid_o & head.done;
    assign iter_cnt_o = iter_cnt_q;

    // Only one request is ever outstanding, so a free slot now is a reserved slot for its response.
`ifdef HWPE_CTRL_ULOOP_ISSUER_PREFETCH_EN
    assign issue_ok = (fifo_occ < OCC_WIDTH'(FIFO_DEPTH));
`else
    assign issue_ok = fifo_empty & ~fifo_pop;
`endif

    for (genvar r = 0; r < NB_REG; r++) begin : g_offs
        if (r < ULOOP_NB_REG) begin : g_map
            assign offs_o[r*REG_WIDTH +: REG_WIDTH] = valid_o ? REG_WIDTH'(head.offs[r]) : '0;
        end else begin : g_zero
            assign offs_o[r*REG_WIDTH +: REG_WIDTH] = '0;
        end
    end

    for (genvar l = 0; l < NB_LOOPS; l++) begin : g_idx
        if (l < ULOOP_NB_LOOPS) begin : g_map
            assign idx_o[l*CNT_WIDTH +: CNT_WIDTH] = valid_o ? CNT_WIDTH'(head.idx[l]) : '0;
        end else begin : g_zero
            assign idx_o[l*CNT_WIDTH +: CNT_WIDTH] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ISS_IDLE;
            iter_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        fifo_push  = 1'b0;
        unique case (state_q)
            ISS_IDLE: begin
                if (start_i) begin
                    state_d    = ISS_CLEAR;
                    iter_cnt_d = '0;
                end
            end
            ISS_CLEAR: state_d = ISS_REQ;
            ISS_REQ: begin
                if (issue_ok) state_d = ISS_WAIT;
            end
            ISS_WAIT: begin
                if (flags_i.valid) begin
                    fifo_push  = 1'b1;
                    iter_cnt_d = (iter_cnt_q == '1) ? iter_cnt_q : iter_cnt_q + CNT_WIDTH'(1);
                    state_d    = flags_i.done ? ISS_DRAIN : ISS_REQ;
                end
            end
            ISS_DRAIN: begin
                // Leave as the last entry is popped so done_o follows it by one cycle.
                if (fifo_empty || ((fifo_occ == OCC_WIDTH'(1)) && fifo_pop)) state_d = ISS_DONE;
            end
            ISS_DONE: state_d = ISS_IDLE;
            default:  state_d = ISS_IDLE;
        endcase
        if (clear_i) begin
            state_d    = ISS_IDLE;
            iter_cnt_d = '0;
            fifo_push  = 1'b0;
        end
    end

    always_comb begin
        ctrl_o        = '0;
        busy_o        = (state_q != ISS_IDLE);
        done_o        = (state_q == ISS_DONE);
        ctrl_o.enable = (state_q == ISS_REQ) & issue_ok & ~clear_i;
        ctrl_o.clear  = clear_i | (state_q == ISS_CLEAR);
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_push |-> (!fifo_full || fifo_pop));
`endif

endmodule

`default_nettype wire

// File: tb/tb_hwpe_ctrl_uloop_issuer.sv
// Directed self-checking bench for hwpe_ctrl_uloop_issuer with a latency-programmable engine model.
`default_nettype none
`timescale 1ns/1ps

module tb_hwpe_ctrl_uloop_issuer;
    import hwpe_ctrl_package::*;

    localparam int NB_REG     = 4;
    localparam int REG_WIDTH  = 32;
    localparam int NB_LOOPS   = 6;
    localparam int CNT_WIDTH  = 16;
    localparam int FIFO_DEPTH = 2;
`ifdef HWPE_CTRL_ULOOP_ISSUER_PREFETCH_EN
    localparam int EXP_STALL  = FIFO_DEPTH;
`else
    localparam int EXP_STALL  = 1;
`endif

    logic clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0, start_i = 1'b0, ready_i = 1'b0;
    logic busy_o, done_o, valid_o, last_o;
    ctrl_uloop_t  ctrl_o;
    flags_uloop_t flags_i;
    logic [NB_REG*REG_WIDTH-1:0]   offs_o;
    logic [NB_LOOPS*CNT_WIDTH-1:0] idx_o;
    logic [CNT_WIDTH-1:0]          iter_cnt_o;

    // Narrow-counter instance for saturation
    logic sat_start = 1'b0, sat_clear = 1'b0, sat_ready = 1'b1, sat_en_d = 1'b0;
    logic sat_busy, sat_done, sat_valid, sat_last;
    ctrl_uloop_t  sat_ctrl;
    flags_uloop_t sat_flags;
    logic [NB_REG*REG_WIDTH-1:0] sat_offs;
    logic [NB_LOOPS*4-1:0]       sat_idx;
    logic [3:0]                  sat_iter;

    always #5 clk_i = ~clk_i;

    hwpe_ctrl_uloop_issuer #(
        .NB_REG(NB_REG), .REG_WIDTH(REG_WIDTH), .NB_LOOPS(NB_LOOPS),
        .CNT_WIDTH(CNT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .ctrl_o(ctrl_o), .flags_i(flags_i),
        .valid_o(valid_o), .ready_i(ready_i), .offs_o(offs_o), .idx_o(idx_o),
        .last_o(last_o), .iter_cnt_o(iter_cnt_o)
    );

    hwpe_ctrl_uloop_issuer #(
        .NB_REG(NB_REG), .REG_WIDTH(REG_WIDTH), .NB_LOOPS(NB_LOOPS),
        .CNT_WIDTH(4), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(sat_clear), .start_i(sat_start),
        .busy_o(sat_busy), .done_o(sat_done), .ctrl_o(sat_ctrl), .flags_i(sat_flags),
        .valid_o(sat_valid), .ready_i(sat_ready), .offs_o(sat_offs), .idx_o(sat_idx),
        .last_o(sat_last), .iter_cnt_o(sat_iter)
    );

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [NB_REG*REG_WIDTH-1:0] exp_offs(input int n);
        logic [NB_REG*REG_WIDTH-1:0] v;
        for (int r = 0; r < NB_REG; r++) v[r*REG_WIDTH +: REG_WIDTH] = REG_WIDTH'(32'h10 * (r + 1) + n * 32'h100);
        return v;
    endfunction

    function automatic logic [NB_LOOPS*CNT_WIDTH-1:0] exp_idx(input int n);
        logic [NB_LOOPS*CNT_WIDTH-1:0] v;
        for (int l = 0; l < NB_LOOPS; l++) v[l*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(n * 8 + l);
        return v;
    endfunction

    // Engine model: answers each enable after lat_tab[step] cycles
    int eng_cnt = 0, step = 0, job_len = 4, en_cnt = 0, en_overlap = 0;
    int lat_tab [8];

    always @(negedge clk_i) begin
        flags_i.valid = 1'b0;
        flags_i.done  = 1'b0;
        if (clear_i || !rst_ni) begin
            eng_cnt = 0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    flags_i.valid = 1'b1;
                    flags_i.done  = (step == job_len - 1);
                    flags_i.offs  = exp_offs(step);
                    flags_i.idx   = exp_idx(step);
                    step++;
                end
            end
            if (ctrl_o.enable) begin
                en_cnt++;
                if (eng_cnt > 0) en_overlap++;
                eng_cnt = lat_tab[step % 8];
            end
        end
    end

    always @(negedge clk_i) begin
        sat_flags.valid = sat_en_d;
        sat_en_d        = sat_ctrl.enable;
    end

    // Consumer monitor
    int cyc = 0, pop_idx = 0, done_cnt = 0, clr_cnt = 0, last_pop_cyc = 0, done_cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (ctrl_o.clear) clr_cnt++;
            if (valid_o && ready_i) begin
                check("pop_offs", offs_o, exp_offs(pop_idx));
                check("pop_idx", idx_o, exp_idx(pop_idx));
                check("pop_last", last_o, pop_idx == job_len - 1);
                if (last_o) last_pop_cyc = cyc;
                pop_idx++;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic setup_job(input int len);
        job_len = len;
        step    = 0;
        pop_idx = 0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check("done_seen", done_cnt - d0, 1);
    endtask

    int e0, c0, d0;

    initial begin
        flags_i   = '0;
        sat_flags = '0;
        lat_tab   = '{1, 1, 1, 1, 1, 1, 1, 1};
        repeat (3) tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_last", last_o, 0);
        check("rst_ctrl", ctrl_o, 2'b00);
        check("rst_iter", iter_cnt_o, 0);
        check("rst_offs", offs_o, 0);
        check("rst_idx", idx_o, 0);

        // Serial job, 4 steps, latency 1, consumer always ready
        tick();
        setup_job(4);
        e0 = en_cnt; c0 = clr_cnt;
        ready_i = 1'b1;
        pulse_start();
        wait_done(200);
        check("job1_enables", en_cnt - e0, 4);
        check("job1_iter", iter_cnt_o, 4);
        check("job1_pops", pop_idx, 4);
        check("job1_done_after_pop", done_cyc - last_pop_cyc, 1);
        check("job1_clear_pulses", clr_cnt - c0, 1);
        @(negedge clk_i);
        check("job1_idle_busy", busy_o, 0);

        // Variable latency 1/5/17, with a start pulse while busy
        tick();
        lat_tab = '{1, 5, 17, 1, 1, 1, 1, 1};
        setup_job(3);
        e0 = en_cnt; c0 = clr_cnt;
        pulse_start();
        repeat (6) tick();
        check("job2_busy", busy_o, 1);
        pulse_start();
        wait_done(300);
        check("job2_enables", en_cnt - e0, 3);
        check("job2_iter", iter_cnt_o, 3);
        check("job2_pops", pop_idx, 3);
        check("job2_clear_pulses", clr_cnt - c0, 1);
        check("job2_overlap", en_overlap, 0);

        // Backpressure: consumer stalled, then ready for exactly one cycle
        tick();
        lat_tab = '{default: 1};
        setup_job(8);
        e0 = en_cnt; d0 = done_cnt;
        ready_i = 1'b0;
        pulse_start();
        repeat (30) tick();
        check("bp_stall_enables", en_cnt - e0, EXP_STALL);
        check("bp_valid", valid_o, 1);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        repeat (30) tick();
        check("bp_after_pop_enables", en_cnt - e0, EXP_STALL + 1);
        check("bp_pops", pop_idx, 1);
        check("bp_iter", iter_cnt_o, EXP_STALL + 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        @(negedge clk_i);
        check("bp_abort_busy", busy_o, 0);
        check("bp_abort_done", done_cnt - d0, 0);

        // Clear with one entry buffered and a response still outstanding
        tick();
        lat_tab = '{1, 20, 1, 1, 1, 1, 1, 1};
        setup_job(4);
        d0 = done_cnt;
        pulse_start();
        repeat (8) tick();
        check("clr_pre_valid", valid_o, 1);
        check("clr_pre_iter", iter_cnt_o, 1);
        clear_i = 1'b1;
        @(negedge clk_i);
        check("clr_ctrl_clear", ctrl_o.clear, 1);
        check("clr_ctrl_enable", ctrl_o.enable, 0);
        tick();
        clear_i = 1'b0;
        @(negedge clk_i);
        check("clr_valid", valid_o, 0);
        check("clr_busy", busy_o, 0);
        check("clr_iter", iter_cnt_o, 0);
        check("clr_offs", offs_o, 0);
        repeat (30) tick();
        check("clr_no_done", done_cnt - d0, 0);

        // Clean job after the abort
        lat_tab = '{default: 1};
        setup_job(2);
        e0 = en_cnt;
        ready_i = 1'b1;
        pulse_start();
        wait_done(200);
        check("job3_enables", en_cnt - e0, 2);
        check("job3_iter", iter_cnt_o, 2);
        check("job3_pops", pop_idx, 2);
        check("overlap_total", en_overlap, 0);

        // Saturation of a 4-bit step counter
        tick();
        sat_start = 1'b1;
        tick();
        sat_start = 1'b0;
        repeat (20) tick();
        check("sat_partial_nonzero", sat_iter != 4'h0, 1);
        repeat (130) tick();
        check("sat_iter", sat_iter, 4'hF);
        check("sat_busy", sat_busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
